// File: rtl/vga_write_port_arbiter.sv
// Single write port of the VGA frame buffer, shared between draw writes and a
// full-frame clear sweep; draws seen during a sweep are parked and replayed after it.
`ifndef VGA_H_BITS
`define VGA_H_BITS 10
`endif
`ifndef VGA_V_BITS
`define VGA_V_BITS 10
`endif
`ifndef VGA_COLS
`define VGA_COLS 640
`endif
`ifndef VGA_ROWS
`define VGA_ROWS 480
`endif
`ifndef BYTE_BITS
`define BYTE_BITS 8
`endif

module vga_write_port_arbiter #(
   parameter int H_BITS = `VGA_H_BITS,
   parameter int V_BITS = `VGA_V_BITS,
   parameter int COLS = `VGA_COLS,
   parameter int ROWS = `VGA_ROWS,
   parameter logic [`BYTE_BITS-1:0] CLEAR_COLOR = 8'b00000000,
   parameter int DROP_BITS = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_en,
   input  logic                   clear_req,
   input  logic                   draw_wr_en,
   input  logic [H_BITS-1:0]      draw_x,
   input  logic [V_BITS-1:0]      draw_y,
   input  logic [`BYTE_BITS-1:0]  draw_byte,
   output logic                   buf_wr_en,
   output logic [H_BITS-1:0]      buf_wr_x,
   output logic [V_BITS-1:0]      buf_wr_y,
   output logic [`BYTE_BITS-1:0]  buf_byte,
   output logic                   clearing,
   output logic                   clear_done,
   output logic [DROP_BITS-1:0]   drop_cnt
);

   localparam int TUPLE_BITS = H_BITS + V_BITS + `BYTE_BITS;
   localparam logic [H_BITS-1:0] LAST_X = H_BITS'(COLS - 1);
   localparam logic [V_BITS-1:0] LAST_Y = V_BITS'(ROWS - 1);

   generate
      if ((COLS < 1) || (ROWS < 1) || ((COLS - 1) >= (1 << H_BITS)) || ((ROWS - 1) >= (1 << V_BITS))) begin : gBadGeometry
         $error("vga_write_port_arbiter: COLS-1/ROWS-1 do not fit the coordinate widths");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      REPLAY
   } state_t;

   state_t                  state_q;
   logic [H_BITS-1:0]       sx_q;
   logic [V_BITS-1:0]       sy_q;
   logic [TUPLE_BITS-1:0]   last_q;
   logic                    lastValid_q;
   logic [TUPLE_BITS-1:0]   pend_q;
   logic                    pendValid_q;
   logic                    wrEn_q;
   logic [H_BITS-1:0]       bufX_q;
   logic [V_BITS-1:0]       bufY_q;
   logic [`BYTE_BITS-1:0]   bufByte_q;
   logic                    clearing_q;
   logic                    done_q;
   logic [DROP_BITS-1:0]    dropCnt_q;

   logic [TUPLE_BITS-1:0]   drawTuple;
   logic                    drawIsNew;
   logic                    pendOverwrite;
   logic                    sweepLast;
   logic [DROP_BITS-1:0]    dropCnt_d;

   assign drawTuple     = {draw_x, draw_y, draw_byte};
   assign drawIsNew     = !lastValid_q || (drawTuple != last_q);
   assign pendOverwrite = draw_wr_en && pendValid_q && (pend_q != drawTuple);
   assign sweepLast     = (sx_q == LAST_X) && (sy_q == LAST_Y);
   assign dropCnt_d     = (&dropCnt_q) ? dropCnt_q : dropCnt_q + 1'b1;

   // One FSM owns every output register; the strobes are cleared whenever the
   // module is stalled so a write is never repeated across a clk_en gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sx_q        <= '0;
         sy_q        <= '0;
         last_q      <= '0;
         lastValid_q <= 1'b0;
         pend_q      <= '0;
         pendValid_q <= 1'b0;
         wrEn_q      <= 1'b0;
         bufX_q      <= '0;
         bufY_q      <= '0;
         bufByte_q   <= '0;
         clearing_q  <= 1'b0;
         done_q      <= 1'b0;
         dropCnt_q   <= '0;
      end else if (!clk_en) begin
         wrEn_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         wrEn_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (clear_req) begin
                  state_q    <= CLEAR;
                  clearing_q <= 1'b1;
                  sx_q       <= '0;
                  sy_q       <= '0;
                  if (draw_wr_en) begin
                     pend_q      <= drawTuple;
                     pendValid_q <= 1'b1;
                     if (pendOverwrite) dropCnt_q <= dropCnt_d;
                  end
               end else if (draw_wr_en && drawIsNew) begin
                  wrEn_q                        <= 1'b1;
                  {bufX_q, bufY_q, bufByte_q}   <= drawTuple;
                  last_q                        <= drawTuple;
                  lastValid_q                   <= 1'b1;
               end
            end
            CLEAR: begin
               wrEn_q    <= 1'b1;
               bufX_q    <= sx_q;
               bufY_q    <= sy_q;
               bufByte_q <= CLEAR_COLOR;
               if (draw_wr_en) begin
                  pend_q      <= drawTuple;
                  pendValid_q <= 1'b1;
                  if (pendOverwrite) dropCnt_q <= dropCnt_d;
               end
               // A fresh request restarts the raster; the pixel in flight still goes out.
               if (clear_req) begin
                  sx_q <= '0;
                  sy_q <= '0;
               end else if (sweepLast) begin
                  state_q    <= REPLAY;
                  clearing_q <= 1'b0;
                  done_q     <= 1'b1;
                  sx_q       <= '0;
                  sy_q       <= '0;
               end else if (sx_q == LAST_X) begin
                  sx_q <= '0;
                  sy_q <= sy_q + 1'b1;
               end else begin
                  sx_q <= sx_q + 1'b1;
               end
            end
            REPLAY: begin
               lastValid_q <= 1'b0;
               if (clear_req) begin
                  state_q    <= CLEAR;
                  clearing_q <= 1'b1;
                  sx_q       <= '0;
                  sy_q       <= '0;
                  if (draw_wr_en) begin
                     pend_q      <= drawTuple;
                     pendValid_q <= 1'b1;
                     if (pendOverwrite) dropCnt_q <= dropCnt_d;
                  end
               end else begin
                  state_q     <= IDLE;
                  pendValid_q <= 1'b0;
                  if (draw_wr_en) begin
                     wrEn_q                      <= 1'b1;
                     {bufX_q, bufY_q, bufByte_q} <= drawTuple;
                     last_q                      <= drawTuple;
                     lastValid_q                 <= 1'b1;
                  end else if (pendValid_q) begin
                     wrEn_q                      <= 1'b1;
                     {bufX_q, bufY_q, bufByte_q} <= pend_q;
                     last_q                      <= pend_q;
                     lastValid_q                 <= 1'b1;
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               clearing_q <= 1'b0;
            end
         endcase
      end
   end

   assign buf_wr_en  = wrEn_q;
   assign buf_wr_x   = bufX_q;
   assign buf_wr_y   = bufY_q;
   assign buf_byte   = bufByte_q;
   assign clearing   = clearing_q;
   assign clear_done = done_q;
   assign drop_cnt   = dropCnt_q;

endmodule

// File: tb/tb_vga_write_port_arbiter.sv
// Directed bench for vga_write_port_arbiter on a 4x3 frame: draw dedupe table,
// clear sweeps, pending replay, sweep restart, clk_en stalls and async reset.
module tb_vga_write_port_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       clkEn;
   logic       clearReq;
   logic       drawWrEn;
   logic [2:0] drawX;
   logic [1:0] drawY;
   logic [7:0] drawByte;
   logic       bufWrEn;
   logic [2:0] bufWrX;
   logic [1:0] bufWrY;
   logic [7:0] bufByte;
   logic       clearing;
   logic       clearDone;
   logic [7:0] dropCnt;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       we;
      logic [2:0] x;
      logic [1:0] y;
      logic [7:0] b;
      logic       eWe;
      logic [2:0] eX;
      logic [1:0] eY;
      logic [7:0] eB;
   } vec_t;

   vec_t vecs[10];

   vga_write_port_arbiter #(
      .H_BITS(3),
      .V_BITS(2),
      .COLS(4),
      .ROWS(3),
      .CLEAR_COLOR(8'h00),
      .DROP_BITS(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clk_en(clkEn),
      .clear_req(clearReq),
      .draw_wr_en(drawWrEn),
      .draw_x(drawX),
      .draw_y(drawY),
      .draw_byte(drawByte),
      .buf_wr_en(bufWrEn),
      .buf_wr_x(bufWrX),
      .buf_wr_y(bufWrY),
      .buf_byte(bufByte),
      .clearing(clearing),
      .clear_done(clearDone),
      .drop_cnt(dropCnt)
   );

   always #5 clk = ~clk;

   // Drive inputs on the falling edge, let one rising edge act on them, then sample.
   task automatic applyStimulus(input logic en, input logic clr, input logic we,
                                input logic [2:0] x, input logic [1:0] y, input logic [7:0] b);
      @(negedge clk);
      clkEn    = en;
      clearReq = clr;
      drawWrEn = we;
      drawX    = x;
      drawY    = y;
      drawByte = b;
      @(posedge clk);
      #1;
   endtask

   // Coordinates and data are only compared when a write strobe is expected.
   task automatic checkOutput(input string name, input logic eWe, input logic [2:0] eX,
                              input logic [1:0] eY, input logic [7:0] eB, input logic eClr,
                              input logic eDone, input logic [7:0] eDrop);
      logic ok;
      ok = (bufWrEn === eWe) && (clearing === eClr) && (clearDone === eDone) && (dropCnt === eDrop);
      if (eWe) ok = ok && (bufWrX === eX) && (bufWrY === eY) && (bufByte === eB);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL %s: got we=%0b x=%0d y=%0d byte=%h clearing=%0b done=%0b drop=%0d, want we=%0b x=%0d y=%0d byte=%h clearing=%0b done=%0b drop=%0d",
                  name, bufWrEn, bufWrX, bufWrY, bufByte, clearing, clearDone, dropCnt,
                  eWe, eX, eY, eB, eClr, eDone, eDrop);
      end
   endtask

   task automatic checkZeroCoords(input string name);
      checks++;
      if ({bufWrX, bufWrY, bufByte} !== 13'd0) begin
         errors++;
         $display("[TB] FAIL %s: got x=%0d y=%0d byte=%h, want all zero", name, bufWrX, bufWrY, bufByte);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b1, 3'd2, 2'd1, 8'hFF};
      vecs[1] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b0, 3'd0, 2'd0, 8'h00};
      vecs[2] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b0, 3'd0, 2'd0, 8'h00};
      vecs[3] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b0, 3'd0, 2'd0, 8'h00};
      vecs[4] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b0, 3'd0, 2'd0, 8'h00};
      vecs[5] = '{1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 3'd0, 2'd0, 8'h00};
      vecs[6] = '{1'b1, 3'd3, 2'd2, 8'h15, 1'b1, 3'd3, 2'd2, 8'h15};
      vecs[7] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b1, 3'd2, 2'd1, 8'hFF};
      vecs[8] = '{1'b1, 3'd2, 2'd1, 8'hFF, 1'b0, 3'd0, 2'd0, 8'h00};
      vecs[9] = '{1'b1, 3'd3, 2'd2, 8'h15, 1'b1, 3'd3, 2'd2, 8'h15};

      reset    = 1'b1;
      clkEn    = 1'b1;
      clearReq = 1'b0;
      drawWrEn = 1'b0;
      drawX    = '0;
      drawY    = '0;
      drawByte = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset state", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);
      checkZeroCoords("reset coords");
      reset = 1'b0;

      // Draw writes in IDLE: first issues, identical repeats suppressed
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, vecs[i].we, vecs[i].x, vecs[i].y, vecs[i].b);
         checkOutput($sformatf("idle vec %0d", i), vecs[i].eWe, vecs[i].eX, vecs[i].eY, vecs[i].eB,
                     1'b0, 1'b0, 8'd0);
      end

      // Plain full-frame clear
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t2 enter clear", 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
         checkOutput($sformatf("t2 pixel %0d", i), 1'b1, 3'(i % 4), 2'(i / 4), 8'h00,
                     i < 11, i == 11, 8'd0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t2 replay empty", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);

      // Draws during a sweep: overwrite counted, newest replayed once
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t3 enter clear", 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 12; i++) begin
         if (i == 2) applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 2'd1, 8'hFF);
         else        applyStimulus(1'b1, 1'b0, i >= 4, 3'd2, 2'd2, 8'h15);
         checkOutput($sformatf("t3 pixel %0d", i), 1'b1, 3'(i % 4), 2'(i / 4), 8'h00,
                     i < 11, i == 11, (i >= 4) ? 8'd1 : 8'd0);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 2'd2, 8'h15);
      checkOutput("t3 replay write", 1'b1, 3'd2, 2'd2, 8'h15, 1'b0, 1'b0, 8'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 2'd2, 8'h15);
         checkOutput($sformatf("t3 held repeat %0d", i), 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd1);
      end

      // Restart the sweep at pixel 5
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t4 enter clear", 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
         checkOutput($sformatf("t4 pre pixel %0d", i), 1'b1, 3'(i % 4), 2'(i / 4), 8'h00,
                     1'b1, 1'b0, 8'd1);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t4 restart pixel", 1'b1, 3'd1, 2'd1, 8'h00, 1'b1, 1'b0, 8'd1);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
         checkOutput($sformatf("t4 pixel %0d", i), 1'b1, 3'(i % 4), 2'(i / 4), 8'h00,
                     i < 11, i == 11, 8'd1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t4 replay", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd1);

      // clk_en stall mid-sweep
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t5 enter clear", 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd1);
      for (int i = 0; i < 12; i++) begin
         if (i == 3) begin
            for (int s = 0; s < 2; s++) begin
               applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
               checkOutput($sformatf("t5 stall %0d", s), 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd1);
            end
         end
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
         checkOutput($sformatf("t5 pixel %0d", i), 1'b1, 3'(i % 4), 2'(i / 4), 8'h00,
                     i < 11, i == 11, 8'd1);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t5 replay", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd1);

      // Asynchronous reset in the middle of a sweep
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 8'h00);
      checkOutput("t6 enter clear", 1'b0, 3'd0, 2'd0, 8'h00, 1'b1, 1'b0, 8'd1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 8'h00);
         checkOutput($sformatf("t6 pixel %0d", i), 1'b1, 3'(i % 4), 2'(i / 4), 8'h00,
                     1'b1, 1'b0, 8'd1);
      end
      #2 reset = 1'b1;
      #1;
      checkOutput("t6 async reset", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);
      checkZeroCoords("t6 async reset coords");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 8'hFF);
      checkOutput("t6 draw after reset", 1'b1, 3'd2, 2'd1, 8'hFF, 1'b0, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 8'hFF);
      checkOutput("t6 repeat after reset", 1'b0, 3'd0, 2'd0, 8'h00, 1'b0, 1'b0, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
